// File: rtl/ifu_axi_fetch_bridge_pkg.sv
// Shared constants and types for the IFU-to-AXI4-Lite fetch bridge.
// Holds the bus widths, the AXI response and protection codes, and the FSM state encoding.
package ifu_axi_fetch_bridge_pkg;

    localparam int          PC_SIZE       = 32;
    localparam int          INSTR_SIZE    = 32;
    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0]  IFU_ARPROT    = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } fetch_state_e;

    function automatic logic pc_is_misaligned(input logic [1:0] pc_lsbs);
        return pc_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_axi_fetch_bridge_rsp_holdreg.sv
// Response holding register: captures the instruction word and error flag once per fetch
// and keeps them stable while the IFU has not yet accepted the response.
module ifu_rsp_holdreg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              err_in,
    output logic [DATA_W-1:0] instr_out,
    output logic              err_out
);

    logic [DATA_W-1:0] instr_d, instr_q;
    logic              err_d, err_q;

    // An erroring fetch never exposes bus data to the IFU.
    always_comb begin
        instr_d = instr_q;
        err_d   = err_q;
        if (load) begin
            instr_d = err_in ? '0 : instr_in;
            err_d   = err_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    assign instr_out = instr_q;
    assign err_out   = err_q;

endmodule

// File: rtl/ifu_axi_fetch_bridge.sv
// IFU fetch REQ/RSP to single-beat AXI4-Lite read bridge, one fetch outstanding at a time.
// Misaligned PCs complete locally with an error; bus errors are reported the same way.
import ifu_axi_fetch_bridge_pkg::*;

module ifu_axi_fetch_bridge #(
    parameter int         ADDR_W   = PC_SIZE,
    parameter int         DATA_W   = INSTR_SIZE,
    parameter logic [2:0] ARPROT_V = IFU_ARPROT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_pc,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DATA_W-1:0] ifu_rsp_instr,
    output logic              ifu_rsp_err,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              misaligned;
    logic              start_fetch;
    logic              hold_load;
    logic              hold_err;

    assign misaligned = pc_is_misaligned(ifu_req_pc[1:0]);

    // In RESP a new request is only taken together with the pending response's handshake.
    assign start_fetch = ifu_req_valid &&
                         ((state_q == ST_IDLE) || ((state_q == ST_RESP) && ifu_rsp_ready));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            araddr_q <= '0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_fetch) state_d = misaligned ? ST_RESP : ST_ADDR;
            ST_ADDR: if (m_arready)   state_d = ST_DATA;
            ST_DATA: if (m_rvalid)    state_d = ST_RESP;
            ST_RESP: begin
                if (start_fetch)        state_d = misaligned ? ST_RESP : ST_ADDR;
                else if (ifu_rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        araddr_d = araddr_q;
        if (start_fetch && !misaligned) araddr_d = {ifu_req_pc[ADDR_W-1:2], 2'b00};
    end

    always_comb begin
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        m_arvalid     = 1'b0;
        m_rready      = 1'b0;
        case (state_q)
            ST_IDLE: ifu_req_ready = 1'b1;
            ST_ADDR: m_arvalid     = 1'b1;
            ST_DATA: m_rready      = 1'b1;
            ST_RESP: begin
                ifu_req_ready = 1'b1;
                ifu_rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_araddr = araddr_q;
    assign m_arprot = ARPROT_V;

    // Only DATA consumes bus data, so any other load comes from a misaligned request.
    assign hold_load = (start_fetch && misaligned) || ((state_q == ST_DATA) && m_rvalid);
    assign hold_err  = (state_q == ST_DATA) ? (m_rresp != AXI_RESP_OKAY) : 1'b1;

    ifu_rsp_holdreg #(
        .DATA_W (DATA_W)
    ) u_rsp_holdreg (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .instr_in  (m_rdata),
        .err_in    (hold_err),
        .instr_out (ifu_rsp_instr),
        .err_out   (ifu_rsp_err)
    );

endmodule

// File: tb/tb_ifu_axi_fetch_bridge.sv
// Self-checking bench for ifu_axi_fetch_bridge: table of fetches with a response scoreboard,
// plus hand-written back-to-back, ignored-input and mid-transaction reset sequences.
module tb_ifu_axi_fetch_bridge;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_wait;
        int          r_wait;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_err;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    int   n_checks;
    int   n_pass;
    rsp_t sb[$];
    vec_t vecs[8];

    ifu_axi_fetch_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_pc    (ifu_req_pc),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_instr (ifu_rsp_instr),
        .ifu_rsp_err   (ifu_rsp_err),
        .m_arvalid     (m_arvalid),
        .m_arready     (m_arready),
        .m_araddr      (m_araddr),
        .m_arprot      (m_arprot),
        .m_rvalid      (m_rvalid),
        .m_rready      (m_rready),
        .m_rdata       (m_rdata),
        .m_rresp       (m_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The stimulus must never offer a request while a response is pending without accepting it.
    always @(posedge clk) begin
        if (rst && ifu_rsp_valid && ifu_req_valid && !ifu_rsp_ready)
            $error("[TB] request offered in RESP without rsp_ready");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the AXI slave side from the cycle after the request was taken until RESP.
    task automatic axi_phase(input logic [31:0] pc, input logic [31:0] rdata,
                             input logic [1:0] rresp, input int ar_wait, input int r_wait);
        if (pc[1:0] != 2'b00) begin
            chk("misaligned_no_arvalid", {31'd0, m_arvalid}, 32'd0);
            return;
        end
        for (int i = 0; i < ar_wait; i++) begin
            chk("ar_stall_arvalid", {31'd0, m_arvalid}, 32'd1);
            chk("ar_stall_araddr", m_araddr, pc);
            chk("ar_stall_rready", {31'd0, m_rready}, 32'd0);
            step();
        end
        chk("arvalid", {31'd0, m_arvalid}, 32'd1);
        chk("araddr", m_araddr, pc);
        chk("arprot", {29'd0, m_arprot}, 32'd4);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        for (int i = 0; i < r_wait; i++) begin
            chk("r_stall_rready", {31'd0, m_rready}, 32'd1);
            chk("r_stall_arvalid", {31'd0, m_arvalid}, 32'd0);
            chk("r_stall_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd0);
            step();
        end
        chk("rready", {31'd0, m_rready}, 32'd1);
        m_rvalid = 1'b1;
        m_rdata  = rdata;
        m_rresp  = rresp;
        step();
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        m_rresp  = 2'b00;
        chk("rready_after_data", {31'd0, m_rready}, 32'd0);
    endtask

    task automatic check_rsp();
        rsp_t e;
        chk("rsp_valid", {31'd0, ifu_rsp_valid}, 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard: got a response, expected none queued");
            return;
        end
        e = sb.pop_front();
        chk("rsp_instr", ifu_rsp_instr, e.instr);
        chk("rsp_err", {31'd0, ifu_rsp_err}, {31'd0, e.err});
    endtask

    task automatic accept_rsp();
        ifu_rsp_ready = 1'b1;
        step();
        ifu_rsp_ready = 1'b0;
        chk("rsp_valid_cleared", {31'd0, ifu_rsp_valid}, 32'd0);
        chk("req_ready_idle", {31'd0, ifu_req_ready}, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        rsp_t e;
        e.instr = v.exp_instr;
        e.err   = v.exp_err;
        sb.push_back(e);
        chk("req_ready", {31'd0, ifu_req_ready}, 32'd1);
        ifu_req_valid = 1'b1;
        ifu_req_pc    = v.pc;
        step();
        ifu_req_valid = 1'b0;
        axi_phase(v.pc, v.rdata, v.rresp, v.ar_wait, v.r_wait);
        check_rsp();
        accept_rsp();
    endtask

    initial begin
        rsp_t e;
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_req_pc    = 32'h0;
        ifu_rsp_ready = 1'b0;
        m_arready     = 1'b0;
        m_rvalid      = 1'b0;
        m_rdata       = 32'h0;
        m_rresp       = 2'b00;

        vecs[0] = '{32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 32'h0000_0413, 1'b0};
        vecs[1] = '{32'h8000_0100, 32'hDEAD_BEEF, 2'b10, 0, 0, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'h8000_0104, 32'h0000_0013, 2'b00, 0, 0, 32'h0000_0013, 1'b0};
        vecs[3] = '{32'h8000_0002, 32'h0000_0000, 2'b00, 0, 0, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h8000_0008, 32'h1234_5678, 2'b00, 5, 4, 32'h1234_5678, 1'b0};
        vecs[5] = '{32'h8000_0001, 32'h0000_0000, 2'b00, 0, 0, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h0000_0FFC, 32'hABCD_EF01, 2'b11, 1, 2, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 2'b00, 0, 1, 32'hFFFF_FFFF, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, ifu_req_ready}, 32'd1);
        chk("rst_arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("rst_rready", {31'd0, m_rready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd0);
        chk("rst_rsp_instr", ifu_rsp_instr, 32'h0);
        chk("rst_rsp_err", {31'd0, ifu_rsp_err}, 32'd0);
        chk("rst_araddr", m_araddr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Stray AXI inputs while idle must not move the bridge.
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
        m_rdata   = 32'h5555_AAAA;
        step();
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = 32'h0;
        chk("stray_arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("stray_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd0);
        chk("stray_req_ready", {31'd0, ifu_req_ready}, 32'd1);
        chk("stray_instr_held", ifu_rsp_instr, 32'hFFFF_FFFF);

        // Back-to-back: aligned, aligned, misaligned, each taken in the previous RESP cycle.
        e = '{32'h0000_0093, 1'b0};
        sb.push_back(e);
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h8000_0000;
        step();
        ifu_req_valid = 1'b0;
        axi_phase(32'h8000_0000, 32'h0000_0093, 2'b00, 0, 0);
        check_rsp();
        e = '{32'h0010_0113, 1'b0};
        sb.push_back(e);
        chk("b2b_req_ready", {31'd0, ifu_req_ready}, 32'd1);
        ifu_rsp_ready = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h8000_0004;
        step();
        ifu_rsp_ready = 1'b0;
        ifu_req_valid = 1'b0;
        chk("b2b_rsp_dropped", {31'd0, ifu_rsp_valid}, 32'd0);
        axi_phase(32'h8000_0004, 32'h0010_0113, 2'b00, 0, 0);
        check_rsp();
        e = '{32'h0000_0000, 1'b1};
        sb.push_back(e);
        ifu_rsp_ready = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h8000_0006;
        step();
        ifu_rsp_ready = 1'b0;
        ifu_req_valid = 1'b0;
        axi_phase(32'h8000_0006, 32'h0, 2'b00, 0, 0);
        check_rsp();
        accept_rsp();

        // Reset while DATA is waiting on a response that is arriving.
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h8000_0020;
        step();
        ifu_req_valid = 1'b0;
        m_arready     = 1'b1;
        step();
        m_arready = 1'b0;
        chk("pre_rst_rready", {31'd0, m_rready}, 32'd1);
        m_rvalid = 1'b1;
        m_rdata  = 32'h7777_7777;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("async_rst_rready", {31'd0, m_rready}, 32'd0);
        chk("async_rst_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd0);
        chk("async_rst_instr", ifu_rsp_instr, 32'h0);
        chk("async_rst_araddr", m_araddr, 32'h0);
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        applyStimulus('{32'h8000_0010, 32'h00A0_0513, 2'b00, 0, 0, 32'h00A0_0513, 1'b0});

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
